sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Initiator-side engine for the 4-bit magnitude comparator (altb/agtb/aeqb).
- The target value is wired to the comparator's a input; this block drives its b input (probe).
- It binary-searches the unsigned range by reading the three relation flags, and reports the value of a when found.
- It also flags comparator responses that are inconsistent or malformed.

Parameters:
- WIDTH, 4, bit width of probe/result; search range is 0 .. 2^WIDTH-1.
- MAX_PROBES, WIDTH+1, probe budget; exceeding it is an error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a search; sampled in IDLE only
- altb  input  1  comparator flag: a < probe
- agtb  input  1  comparator flag: a > probe
- aeqb  input  1  comparator flag: a == probe
- probe  output  WIDTH  registered value driven to comparator b
- busy  output  1  high in PROBE/CHECK
- done  output  1  one-cycle pulse when a search ends (found or error)
- found  output  1  last search ended with aeqb
- err  output  1  last search ended in error
- result  output  WIDTH  value found (valid when found=1)
- probes_used  output  3  number of probes issued by the last/current search

Behaviour:
- Reset (synchronous, active-high): state=IDLE; probe=0, busy=0, done=0, found=0, err=0, result=0, probes_used=0, lo=0, hi=2^WIDTH-1. Reset mid-search aborts immediately; no done pulse.
- FSM states: IDLE, PROBE, CHECK, DONE.
- IDLE, start=1 at an edge:
  - lo=0, hi=2^WIDTH-1.
  - probe=(lo+hi)>>1, computed WIDTH+1 bits wide, so 7 for WIDTH=4.
  - probes_used=1; found/err cleared; go to PROBE.
- PROBE: one settle cycle, flags ignored → CHECK.
- CHECK samples the flags at the edge:
  - Flags not exactly one-hot → err=1, go to DONE.
  - aeqb → found=1, result=probe, go to DONE.
  - altb:
    - probe==0 → err=1, DONE.
    - Otherwise hi=probe-1, probe=(lo+probe-1)>>1, probes_used+1, go to PROBE.
  - agtb:
    - probe==2^WIDTH-1 → err=1, DONE.
    - Otherwise lo=probe+1, probe=(probe+1+hi)>>1, probes_used+1, go to PROBE.
  - If the updated bounds give lo>hi, or the new probes_used would exceed MAX_PROBES → err=1, DONE, probe unchanged.
- DONE: done=1 for exactly this cycle → IDLE.
- Held values: found, err, result, probes_used and probe persist until the next accepted start.
- start while busy or in DONE is ignored; no queuing.
- Latency: N probes → done asserted in the cycle following edge 2N after the start-accept edge.
- Arithmetic: all bound math is unsigned at WIDTH+1 bits; no wrap-around. Underflow at probe==0 and overflow at probe==max are caught by the error rules above.
- busy=1 exactly in PROBE and CHECK.

Decomposition:
- Shared package `sar_pkg`:
  - state enum {IDLE, PROBE, CHECK, DONE}
  - flag-decode constants for one-hot checks (LT=3'b100, EQ=3'b010, GT=3'b001 in altb,aeqb,agtb order)
- One sub-module: `sar_next_probe` (combinational).
  - Inputs: lo, hi, probe, flags.
  - Outputs: new lo, new hi, new probe, bound-error.
  - Keeps the FSM file small and lets the arithmetic be unit-tested.
- The bench instantiates the existing comparator with a=target, b=probe as the responder.

Test Plan:
- Target a=5:
  - start pulse → probes 7,3,5.
  - done after 6 edges.
  - found=1, result=5, probes_used=3, err=0.
- Target a=15:
  - probes 7,11,13,14,15.
  - done after 10 edges.
  - result=15, probes_used=5; exercises the upper bound without overflow.
- Target a=0 → probes 7,3,1,0; result=0, probes_used=4. Target a=8 → probes 7,11,9,8; result=8, probes_used=4.
- Faulty responder forces altb=1,aeqb=1 on the first CHECK → done after 2 edges; err=1, found=0, probes_used=1.
- Faulty responder forces agtb=1 always → probes 7,11,13,14,15, then err=1 at probe 15, found=0.
- Robustness:
  - Assert rst during the second PROBE of a=5 → next cycle all outputs are 0, state IDLE, no done.
  - start held high through a search → exactly one search, done pulses once.
  - A new search then starts on the IDLE edge after DONE.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR search engine.
package sar_pkg;

    // Search controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sar_state_t;

    // Comparator relation flags, packed as {altb, aeqb, agtb}
    localparam logic [2:0] FLG_LT = 3'b100;
    localparam logic [2:0] FLG_EQ = 3'b010;
    localparam logic [2:0] FLG_GT = 3'b001;

    // A well-formed comparator response has exactly one relation flag set
    function automatic logic flags_onehot(input logic [2:0] f);
        return (f == FLG_LT) || (f == FLG_EQ) || (f == FLG_GT);
    endfunction

endpackage

// File: rtl/sar_next_probe.sv
// Combinational bound/probe update for one binary-search step.
// Bounds are WIDTH+1 bits wide so that hi=probe-1 and lo=probe+1 never wrap.
module sar_next_probe
    import sar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   i_lo,
    input  logic [WIDTH:0]   i_hi,
    input  logic [WIDTH-1:0] i_probe,
    input  logic [2:0]       i_flags,
    output logic [WIDTH:0]   o_lo,
    output logic [WIDTH:0]   o_hi,
    output logic [WIDTH-1:0] o_probe,
    output logic             o_bound_err
);

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'((1 << WIDTH) - 1);

    logic [WIDTH:0] w_p;
    logic [WIDTH:0] w_sum;

    // Narrow the interval toward the side the comparator points at
    always_comb begin
        w_p         = {1'b0, i_probe};
        w_sum       = {i_probe, 1'b0};
        o_lo        = i_lo;
        o_hi        = i_hi;
        o_bound_err = 1'b0;
        case (i_flags)
            FLG_LT: begin
                if (w_p == '0) begin
                    o_bound_err = 1'b1;
                end else begin
                    o_hi  = w_p - 1'b1;
                    w_sum = i_lo + w_p - 1'b1;
                end
            end
            FLG_GT: begin
                if (w_p == MAXV) begin
                    o_bound_err = 1'b1;
                end else begin
                    o_lo  = w_p + 1'b1;
                    w_sum = w_p + 1'b1 + i_hi;
                end
            end
            default: ;
        endcase
        if (o_lo > o_hi) begin
            o_bound_err = 1'b1;
        end
        // On any error the probe stays where it was
        o_probe = o_bound_err ? i_probe : w_sum[WIDTH:1];
    end

endmodule

// File: rtl/sar_search.sv
// Binary-search initiator driving the b side of a magnitude comparator.
// Each probe takes two cycles: PROBE lets the comparator settle, CHECK samples it.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_PROBES = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             altb,
    input  logic             agtb,
    input  logic             aeqb,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       probes_used
);

    localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'((1 << WIDTH) - 1);
    localparam logic [WIDTH-1:0] MID  = MAXV[WIDTH:1];

    sar_state_t       r_state;
    sar_state_t       w_state_nxt;
    logic [WIDTH:0]   r_lo;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_probe;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_used;
    logic             r_found;
    logic             r_err;

    logic [2:0]       w_flags;
    logic [WIDTH:0]   w_lo;
    logic [WIDTH:0]   w_hi;
    logic [WIDTH-1:0] w_probe;
    logic             w_bound_err;
    logic             w_budget_err;
    logic             w_accept;
    logic             w_step;
    logic             w_hit;
    logic             w_fail;

    assign w_flags      = {altb, aeqb, agtb};
    assign w_budget_err = (int'(r_used) + 1) > MAX_PROBES;

    sar_next_probe #(.WIDTH(WIDTH)) u_next (
        .i_lo        (r_lo),
        .i_hi        (r_hi),
        .i_probe     (r_probe),
        .i_flags     (w_flags),
        .o_lo        (w_lo),
        .o_hi        (w_hi),
        .o_probe     (w_probe),
        .o_bound_err (w_bound_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_hit       = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = PROBE;
                end
            end
            PROBE: w_state_nxt = CHECK;
            CHECK: begin
                w_state_nxt = DONE;
                if (!flags_onehot(w_flags)) begin
                    w_fail = 1'b1;
                end else if (w_flags == FLG_EQ) begin
                    w_hit = 1'b1;
                end else if (w_bound_err || w_budget_err) begin
                    w_fail = 1'b1;
                end else begin
                    w_step      = 1'b1;
                    w_state_nxt = PROBE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Search bounds, probe and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo     <= '0;
            r_hi     <= MAXV;
            r_probe  <= '0;
            r_result <= '0;
            r_used   <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_lo    <= '0;
            r_hi    <= MAXV;
            r_probe <= MID;
            r_used  <= 3'd1;
            r_found <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_step) begin
            r_lo    <= w_lo;
            r_hi    <= w_hi;
            r_probe <= w_probe;
            r_used  <= r_used + 3'd1;
        end else if (w_hit) begin
            r_found  <= 1'b1;
            r_result <= r_probe;
        end else if (w_fail) begin
            r_err <= 1'b1;
        end
    end

    assign probe       = r_probe;
    assign busy        = (r_state == PROBE) || (r_state == CHECK);
    assign done        = (r_state == DONE);
    assign found       = r_found;
    assign err         = r_err;
    assign result      = r_result;
    assign probes_used = r_used;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural comparator as responder.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       altb, agtb, aeqb;
    logic [3:0] probe, result;
    logic       busy, done, found, err;
    logic [2:0] probes_used;

    logic [3:0] target = 4'd0;
    int         mode = 0;      // 0 honest, 1 altb+aeqb, 2 agtb stuck
    int         exp_pr [8];
    int         nassert = 0;
    int         nfail = 0;

    sar_search #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .altb        (altb),
        .agtb        (agtb),
        .aeqb        (aeqb),
        .probe       (probe),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .err         (err),
        .result      (result),
        .probes_used (probes_used)
    );

    always #5 clk = ~clk;

    // Comparator responder: a = target, b = probe
    always_comb begin
        case (mode)
            1:       {altb, aeqb, agtb} = 3'b110;
            2:       {altb, aeqb, agtb} = 3'b001;
            default: begin
                altb = (target < probe);
                aeqb = (target == probe);
                agtb = (target > probe);
            end
        endcase
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        nassert++;
        assert (got === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    // One search: checks each probe, the 2N-edge latency and the final flags
    task automatic run(input int tgt, input int md, input int n,
                       input int ef, input int ee, input int er, input int eu);
        target = 4'(tgt);
        mode   = md;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("probe[%0d] a=%0d", k, tgt), 32'(probe), 32'(exp_pr[k]));
            chk("busy_in_search", 32'(busy), 32'd1);
            chk("no_early_done", 32'(done), 32'd0);
            cyc();
            cyc();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("found", 32'(found), 32'(ef));
        chk("err", 32'(err), 32'(ee));
        if (ef != 0) chk("result", 32'(result), 32'(er));
        chk("probes_used", 32'(probes_used), 32'(eu));
        chk("busy_in_done", 32'(busy), 32'd0);
        cyc();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("probe_held", 32'(probe), 32'(exp_pr[n-1]));
    endtask

    initial begin
        int dcount;
        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_probe", 32'(probe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_used", 32'(probes_used), 32'd0);
        cyc();

        // Honest comparator searches
        exp_pr = '{7, 3, 5, 0, 0, 0, 0, 0};
        run(5, 0, 3, 1, 0, 5, 3);
        exp_pr = '{7, 11, 13, 14, 15, 0, 0, 0};
        run(15, 0, 5, 1, 0, 15, 5);
        exp_pr = '{7, 3, 1, 0, 0, 0, 0, 0};
        run(0, 0, 4, 1, 0, 0, 4);
        exp_pr = '{7, 11, 9, 8, 0, 0, 0, 0};
        run(8, 0, 4, 1, 0, 8, 4);

        // Malformed response on first CHECK
        exp_pr = '{7, 0, 0, 0, 0, 0, 0, 0};
        run(5, 1, 1, 0, 1, 0, 1);
        // agtb stuck: walks to the top then overflows
        exp_pr = '{7, 11, 13, 14, 15, 0, 0, 0};
        run(3, 2, 5, 0, 1, 0, 5);

        // Reset during the second PROBE of a=5
        target = 4'd5;
        mode   = 0;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        cyc();
        cyc();
        chk("second_probe", 32'(probe), 32'd3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_probe", 32'(probe), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_found", 32'(found), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_used", 32'(probes_used), 32'd0);
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);

        // start held high: one search, then restart on IDLE edge after DONE
        start = 1'b1;
        cyc();
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (done) dcount++;
        end
        chk("held_done_count", 32'(dcount), 32'd1);
        chk("held_done_now", 32'(done), 32'd1);
        chk("held_result", 32'(result), 32'd5);
        cyc();
        chk("held_idle_busy", 32'(busy), 32'd0);
        chk("held_idle_done", 32'(done), 32'd0);
        chk("held_idle_found", 32'(found), 32'd1);
        cyc();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_probe", 32'(probe), 32'd7);
        chk("restart_used", 32'(probes_used), 32'd1);
        chk("restart_found_clr", 32'(found), 32'd0);
        for (int i = 0; i < 6; i++) cyc();
        chk("restart_done", 32'(done), 32'd1);
        chk("restart_result", 32'(result), 32'd5);
        chk("restart_used_end", 32'(probes_used), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
